// File: rtl/registri_pkg.sv
// Shared definitions for the universal register family.
//   - MODE_*    : 3-bit operation codes applied on each rising clock edge.
//   - max_count : terminal count value for a given width and counter modulus.
package registri_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  // A modulus of 0 selects natural 2^w wrap-around.
  function automatic longint unsigned max_count(input int unsigned w, input int unsigned modulus);
    if (modulus == 0) begin
      return (64'd1 << w) - 64'd1;
    end
    return longint'(modulus) - 64'd1;
  endfunction

endpackage

// File: rtl/ru_next_state.sv
// Combinational next-value multiplexer for the universal register.
//   q_i         : current register content
//   mode_i      : operation select (MODE_* codes)
//   d_i         : parallel load data
//   sin_r_i     : serial bit entering at bit 0 on shift left
//   sin_l_i     : serial bit entering at bit W-1 on shift right
//   q_next_o    : value the register takes on the next edge
//   sout_next_o : outgoing serial bit for shift/rotate, 0 otherwise
module ru_next_state
  import registri_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned MOD = 0
) (
  input  logic [W-1:0] q_i,
  input  logic [2:0]   mode_i,
  input  logic [W-1:0] d_i,
  input  logic         sin_r_i,
  input  logic         sin_l_i,
  output logic [W-1:0] q_next_o,
  output logic         sout_next_o
);

  localparam logic [W-1:0] MaxVal = W'(max_count(W, MOD));

  always_comb begin
    q_next_o    = q_i;
    sout_next_o = 1'b0;
    unique case (mode_i)
      MODE_HOLD: q_next_o = q_i;
      MODE_LOAD: q_next_o = d_i;
      MODE_SHL: begin
        q_next_o    = {q_i[W-2:0], sin_r_i};
        sout_next_o = q_i[W-1];
      end
      MODE_SHR: begin
        q_next_o    = {sin_l_i, q_i[W-1:1]};
        sout_next_o = q_i[0];
      end
      MODE_ROL: begin
        q_next_o    = {q_i[W-2:0], q_i[W-1]};
        sout_next_o = q_i[W-1];
      end
      MODE_ROR: begin
        q_next_o    = {q_i[0], q_i[W-1:1]};
        sout_next_o = q_i[0];
      end
      // >= so that an out-of-range loaded value still wraps to 0.
      MODE_INC: q_next_o = (q_i >= MaxVal) ? '0 : q_i + W'(1);
      MODE_DEC: q_next_o = (q_i == '0) ? MaxVal : q_i - W'(1);
      default:  q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/registro_universale.sv
// W-bit edge-triggered universal register: hold, load, shift, rotate,
// increment and decrement, with registered serial out and a combinational
// terminal-count flag for cascading.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset (q = RESET_VAL, sout = 0)
//   mode  : operation select (MODE_* codes)
//   d     : parallel load data
//   sin_r : serial input at bit 0 on shift left
//   sin_l : serial input at bit W-1 on shift right
//   q     : register content
//   sout  : bit shifted/rotated out on the last edge, else 0
//   tc    : q at terminal value for INC (max) or DEC (0), else 0
module registro_universale
  import registri_pkg::*;
#(
  parameter int unsigned   W         = 8,
  parameter logic [W-1:0]  RESET_VAL = '0,
  parameter int unsigned   MOD       = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [2:0]   mode,
  input  logic [W-1:0] d,
  input  logic         sin_r,
  input  logic         sin_l,
  output logic [W-1:0] q,
  output logic         sout,
  output logic         tc
);

  localparam logic [W-1:0] MaxVal = W'(max_count(W, MOD));

  logic [W-1:0] q_d, q_q;
  logic         sout_d, sout_q;

  ru_next_state #(
    .W   (W),
    .MOD (MOD)
  ) u_next (
    .q_i         (q_q),
    .mode_i      (mode),
    .d_i         (d),
    .sin_r_i     (sin_r),
    .sin_l_i     (sin_l),
    .q_next_o    (q_d),
    .sout_next_o (sout_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q    <= RESET_VAL;
      sout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
    end
  end

  // Exact-match only: out-of-range values never raise tc.
  always_comb begin
    tc = 1'b0;
    if (mode == MODE_INC) begin
      tc = (q_q == MaxVal);
    end else if (mode == MODE_DEC) begin
      tc = (q_q == '0);
    end
  end

  assign q    = q_q;
  assign sout = sout_q;

endmodule

// File: tb/tb_registro_universale.sv
module tb_registro_universale;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // u0: W=8 ; u1: W=4 MOD=0 ; u2/u3: W=4 MOD=10 (u2 lower, u3 upper of cascade)
  logic [2:0] md0 = 3'b000, md1 = 3'b000, md2 = 3'b000, md3_dir = 3'b000;
  logic [7:0] d0 = '0;
  logic [3:0] d1 = '0, d2 = '0, d3 = '0;
  logic       sr0 = 1'b0, sl0 = 1'b0;
  logic       casc = 1'b0;
  logic [2:0] md3;

  logic [7:0] q0;
  logic [3:0] q1, q2, q3;
  logic       so0, so1, so2, so3, tc0, tc1, tc2, tc3;

  assign md3 = casc ? (tc2 ? 3'b110 : 3'b000) : md3_dir;

  registro_universale #(.W(8)) u0 (
    .clock(clock), .reset(reset), .mode(md0), .d(d0), .sin_r(sr0), .sin_l(sl0),
    .q(q0), .sout(so0), .tc(tc0));
  registro_universale #(.W(4), .MOD(0)) u1 (
    .clock(clock), .reset(reset), .mode(md1), .d(d1), .sin_r(1'b0), .sin_l(1'b0),
    .q(q1), .sout(so1), .tc(tc1));
  registro_universale #(.W(4), .MOD(10)) u2 (
    .clock(clock), .reset(reset), .mode(md2), .d(d2), .sin_r(1'b0), .sin_l(1'b0),
    .q(q2), .sout(so2), .tc(tc2));
  registro_universale #(.W(4), .MOD(10)) u3 (
    .clock(clock), .reset(reset), .mode(md3), .d(d3), .sin_r(1'b0), .sin_l(1'b0),
    .q(q3), .sout(so3), .tc(tc3));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int m_q[4];
  int m_so[4];
  int m_w[4]  = '{8, 4, 4, 4};
  int m_mx[4] = '{255, 15, 9, 9};

  // Arithmetic view of each operation on an unsigned w-bit value.
  function automatic void model_step(input int w, input int mx, input int q, input int md,
                                     input int dd, input int sr, input int sl,
                                     output int nq, output int nso);
    int full;
    int half;
    full = 1 << w;
    half = full / 2;
    nq   = q;
    nso  = 0;
    case (md)
      1: nq = dd % full;
      2: begin nso = q / half; nq = (q * 2) % full + sr; end
      3: begin nso = q % 2;    nq = q / 2 + sl * half;   end
      4: begin nso = q / half; nq = (q * 2) % full + nso; end
      5: begin nso = q % 2;    nq = q / 2 + nso * half;  end
      6: nq = (q >= mx) ? 0 : q + 1;
      7: nq = (q == 0) ? mx : q - 1;
      default: nq = q;
    endcase
  endfunction

  function automatic int model_tc(input int q, input int mx, input int md);
    if (md == 6) return (q == mx) ? 1 : 0;
    if (md == 7) return (q == 0) ? 1 : 0;
    return 0;
  endfunction

  function automatic int eff_mode(input int i);
    case (i)
      0: return int'(md0);
      1: return int'(md1);
      2: return int'(md2);
      default: begin
        if (!casc) return int'(md3_dir);
        return (model_tc(m_q[2], m_mx[2], int'(md2)) == 1) ? 6 : 0;
      end
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    int md[4];
    int dd[4];
    int nq[4];
    int nso[4];
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_q[i]  = 0;
        m_so[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) md[i] = eff_mode(i);
      dd = '{int'(d0), int'(d1), int'(d2), int'(d3)};
      for (int i = 0; i < 4; i++) begin
        model_step(m_w[i], m_mx[i], m_q[i], md[i], dd[i],
                   (i == 0) ? int'(sr0) : 0, (i == 0) ? int'(sl0) : 0, nq[i], nso[i]);
      end
      for (int i = 0; i < 4; i++) begin
        m_q[i]  = nq[i];
        m_so[i] = nso[i];
      end
    end
  end

  // Every-cycle compare against the model, mid-cycle.
  logic started = 1'b0;
  always @(negedge clock) begin
    int aq[4];
    int aso[4];
    int atc[4];
    if (started) begin
      aq  = '{int'(q0), int'(q1), int'(q2), int'(q3)};
      aso = '{int'(so0), int'(so1), int'(so2), int'(so3)};
      atc = '{int'(tc0), int'(tc1), int'(tc2), int'(tc3)};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("model_q[%0d]", i), aq[i], m_q[i]);
        chk($sformatf("model_sout[%0d]", i), aso[i], m_so[i]);
        chk($sformatf("model_tc[%0d]", i), atc[i], model_tc(m_q[i], m_mx[i], eff_mode(i)));
      end
    end
  end

  // Advance one edge; inputs change 2 time units after it.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1 reset = 1'b1;
    #2 started = 1'b1;
    step();
    step();
    chk("reset_q0", int'(q0), 0);
    chk("reset_sout0", int'(so0), 0);
    #1 reset = 1'b0;

    // Asynchronous reset mid-cycle.
    md0 = 3'b001; d0 = 8'h5A;
    step();
    chk("load_5a", int'(q0), 'h5A);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_q", int'(q0), 0);
    chk("async_reset_tc_load", int'(tc0), 0);
    #4 reset = 1'b0;
    d0 = 8'hA5;
    step();
    chk("load_a5", int'(q0), 'hA5);

    // Shifts.
    d0 = 8'h81;
    step();
    md0 = 3'b010; sr0 = 1'b1;
    step();
    chk("shl_q", int'(q0), 'h03);
    chk("shl_sout", int'(so0), 1);
    md0 = 3'b011; sl0 = 1'b0;
    step();
    chk("shr_q", int'(q0), 'h01);
    chk("shr_sout", int'(so0), 1);
    md0 = 3'b000;
    step();
    chk("hold_q", int'(q0), 'h01);
    chk("hold_sout", int'(so0), 0);

    // Rotates.
    md0 = 3'b001; d0 = 8'h81;
    step();
    md0 = 3'b100;
    step();
    chk("rol_q", int'(q0), 'h03);
    md0 = 3'b101;
    step();
    chk("ror1_q", int'(q0), 'h81);
    step();
    chk("ror2_q", int'(q0), 'hC0);
    chk("ror2_sout", int'(so0), 1);
    md0 = 3'b000;

    // W=4 natural wrap.
    md1 = 3'b001; d1 = 4'hE;
    step();
    md1 = 3'b110;
    step();
    chk("inc_f", int'(q1), 'hF);
    chk("inc_f_tc", int'(tc1), 1);
    step();
    chk("inc_wrap", int'(q1), 0);
    chk("inc_wrap_tc", int'(tc1), 0);
    md1 = 3'b111;
    #1 chk("dec_zero_tc", int'(tc1), 1);
    step();
    chk("dec_wrap", int'(q1), 'hF);
    md1 = 3'b000;

    // W=4 modulus 10, including out-of-range loads.
    md2 = 3'b001; d2 = 4'd8;
    step();
    md2 = 3'b110;
    step();
    chk("mod_inc_9", int'(q2), 9);
    chk("mod_inc_9_tc", int'(tc2), 1);
    step();
    chk("mod_inc_wrap", int'(q2), 0);
    md2 = 3'b001; d2 = 4'd12;
    step();
    md2 = 3'b110;
    #1 chk("mod_oor_tc_inc", int'(tc2), 0);
    step();
    chk("mod_oor_inc", int'(q2), 0);
    md2 = 3'b001; d2 = 4'd12;
    step();
    md2 = 3'b111;
    step();
    chk("mod_oor_dec", int'(q2), 11);
    chk("mod_oor_dec_tc", int'(tc2), 0);

    // Two-digit decimal cascade.
    md2 = 3'b001; d2 = 4'd0; md3_dir = 3'b001; d3 = 4'd0;
    step();
    md2 = 3'b110; casc = 1'b1;
    for (int k = 0; k < 99; k++) step();
    chk("casc_lo_99", int'(q2), 9);
    chk("casc_hi_99", int'(q3), 9);
    chk("casc_lo_tc", int'(tc2), 1);
    chk("casc_hi_tc", int'(tc3), 1);
    step();
    chk("casc_lo_00", int'(q2), 0);
    chk("casc_hi_00", int'(q3), 0);
    md2 = 3'b000; casc = 1'b0; md3_dir = 3'b000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/registro_universale.md
Name: registro_universale

Overview:
- Parametrised W-bit edge-triggered universal register: the clocked, multi-bit, multi-mode successor to the team's single-bit transparent storage elements.
- Each clock edge performs one operation: hold, parallel load, shift left/right, rotate, increment or decrement.
- Provides serial in/out and terminal-count flags, so one instance serves as a data register, shift register or up/down counter in datapath and sequencing networks.

Parameters:
- W, 8, register width in bits (W >= 2).
- RESET_VAL, {W{1'b0}}, value loaded into q by reset.
- MOD, 0, counter modulus for inc/dec; 0 means natural 2^W wrap, otherwise count range is 0..MOD-1 (requires 2 <= MOD <= 2^W).

Ports:
- clock  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset; forces q = RESET_VAL while high, independent of clock.
- mode   input  3  operation select (encoding in Behaviour).
- d      input  W  parallel load data.
- sin_r  input  1  serial input entering at bit 0 on shift left.
- sin_l  input  1  serial input entering at bit W-1 on shift right.
- q      output W  register content.
- sout   output 1  bit leaving on the last shift: q[W-1] for SHL/ROL, q[0] for SHR/ROR, 0 otherwise.
- tc     output 1  terminal count: q == max in INC mode, q == 0 in DEC mode, 0 in other modes (combinational from q and mode).

Behaviour:
- Reset:
  - While reset = 1: q = RESET_VAL and the internal sout register = 0, asynchronously.
  - tc follows from q and mode.
  - A reset asserted mid-operation aborts that operation with no partial update.
  - On release, the first rising edge with reset = 0 performs the selected mode.
- Mode encoding:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q <= d.
  - 010 SHL: q <= {q[W-2:0], sin_r}.
  - 011 SHR: q <= {sin_l, q[W-1:1]}.
  - 100 ROL: q <= {q[W-2:0], q[W-1]}.
  - 101 ROR: q <= {q[0], q[W-1:1]}.
  - 110 INC: q <= (q == max) ? 0 : q+1.
  - 111 DEC: q <= (q == 0) ? max : q-1.
  - max = 2^W-1 if MOD = 0, else MOD-1.
- Latency: one clock; q reflects the operation after the edge on which mode is sampled.
- Timing: mode, d, sin_r and sin_l must be stable for setup/hold around the rising edge. No transparency: q never follows d combinationally.
- sout is registered: it captures the outgoing bit on each SHL/SHR/ROL/ROR edge and is cleared to 0 on every other operation edge.
- tc is combinational and valid in the same cycle as q. It is the enable for cascading a more-significant instance, which increments/decrements when the lower instance's tc = 1.
- Out-of-range q with MOD != 0 (possible via LOAD or RESET_VAL >= MOD):
  - INC from q >= MOD-1 wraps to 0.
  - DEC from 0 goes to MOD-1.
  - DEC from q >= MOD gives q-1.
  - tc is asserted only on the exact terminal values.
- Arithmetic is unsigned, width W, with no carry beyond tc.

Decomposition:
- Shared package (registri_pkg):
  - mode constants MODE_HOLD..MODE_DEC (3-bit).
  - function computing max from W and MOD.
- One natural sub-module: ru_next_state, a purely combinational next-value multiplexer (q, mode, d, sin_r, sin_l -> q_next, sout_next).
- The top keeps only the asynchronous-reset register and the tc logic.

Test Plan:
- W=8: reset high mid-cycle with q=0x5A -> q=0x00 immediately, without a clock edge; tc=0 in LOAD mode. Release, then LOAD d=0xA5 -> q=0xA5 after one edge.
- W=8, q=0x81: SHL sin_r=1 -> q=0x03, sout=1. Then SHR sin_l=0 -> q=0x01, sout=1. Then HOLD -> q=0x01, sout=0.
- W=8, q=0x81: ROL -> 0x03. ROR twice -> 0x81, then 0xC0.
- W=4, MOD=0: INC from 0xE -> 0xF with tc=1 -> 0x0 with tc=0. DEC from 0x0 -> tc=1, next q=0xF.
- W=4, MOD=10: INC from 8 -> 9 (tc=1) -> 0. LOAD 12, then INC -> 0. LOAD 12, then DEC -> 11 with tc=0.
- Cascade two W=4, MOD=10 instances (lower tc gates upper INC): 99 consecutive increments from 00 -> upper=9, lower=9, both tc=1; the next edge gives 00.
